// File: rtl/raycaster_div_pkg.sv
// rtl/raycaster_div_pkg.sv - shared types and Q-format constants for the ray setup divider
package raycaster_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_FRAC  = 16;

  // Saturation rails of the default Q16.16 format, also used by the multiplier's consumers
  localparam logic [DIV_WIDTH-1:0] Q_MAX = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] Q_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fixed_divider_if.sv
// rtl/fixed_divider_if.sv - operand/result handshake bundle for fixed_divider
interface fixed_divider_if
  import raycaster_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             dbz;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz, ovf
  );

endinterface

// File: rtl/div_sign_sat.sv
// rtl/div_sign_sat.sv - unsigned quotient magnitude to signed Q value with saturation
module div_sign_sat
  import raycaster_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int MAG_W = DIV_WIDTH + DIV_FRAC
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ovf_o
);

  // Negative side reaches one step further than the positive side
  localparam logic [MAG_W-1:0] POS_LIM = (MAG_W'(1) << (WIDTH-1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (WIDTH-1);
  localparam logic [WIDTH-1:0] QMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    q_o   = '0;
    ovf_o = 1'b0;
    if (!neg_i) begin
      if (mag_i > POS_LIM) begin
        q_o   = QMAX;
        ovf_o = 1'b1;
      end else begin
        q_o = mag_i[WIDTH-1:0];
      end
    end else begin
      if (mag_i > NEG_LIM) begin
        q_o   = QMIN;
        ovf_o = 1'b1;
      end else begin
        q_o = -mag_i[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_divider.sv
// rtl/fixed_divider.sv - radix-2 restoring signed fixed-point divider, q = (a << FRAC) / b
module fixed_divider
  import raycaster_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int FRAC  = DIV_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  fixed_divider_if.slave bus
);

  localparam int N     = WIDTH + FRAC;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);
  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]     div_q, div_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH:0]   rem_next;
  logic [N-1:0]     quo_next;
  logic [WIDTH-1:0] sat_q;
  logic             sat_ovf;

  // Magnitudes are unsigned, so the most negative operand maps onto 2^(WIDTH-1) cleanly
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

  assign rem_shift = {rem_q[WIDTH-1:0], div_q[N-1]};
  assign rem_ge    = rem_shift >= {1'b0, bmag_q};
  assign rem_next  = rem_ge ? rem_shift - {1'b0, bmag_q} : rem_shift;
  assign quo_next  = {quo_q[N-2:0], rem_ge};

  // Fed with quo_next so the final quotient bit is folded in on the DONE-entry edge
  div_sign_sat #(
    .WIDTH (WIDTH),
    .MAG_W (N)
  ) u_sat (
    .mag_i (quo_next),
    .neg_i (neg_q),
    .q_o   (sat_q),
    .ovf_o (sat_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          neg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          bmag_d = b_mag;
          div_d  = N'(a_mag) << FRAC;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          if (bus.b == '0) begin
            dbz_d   = 1'b1;
            q_d     = bus.a[WIDTH-1] ? QMIN : QMAX;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        div_d = div_q << 1;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          q_d     = sat_q;
          ovf_d   = sat_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_divider.sv
// tb/tb_fixed_divider.sv - directed self-checking bench for fixed_divider
module tb_fixed_divider;
  import raycaster_div_pkg::*;

  localparam int W = 32;
  localparam int N = 48;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fixed_divider_if #(.WIDTH(W)) bus ();

  fixed_divider #(
    .WIDTH (W),
    .FRAC  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands, wait for accept, then count edges (accept edge = 1) until out_valid
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int lat);
    int guard;
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ir_rise"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eq, input logic edbz, input logic eovf, input int elat);
    int lat;
    issue(av, bv, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, bus.q, eq);
    check({tag, "_dbz"}, 32'(bus.dbz), 32'(edbz));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    retire(tag);
  endtask

  initial begin
    int          lat;
    int          acc [2];
    int          nacc;
    int          cyc;
    logic [31:0] q0;

    tests = 0;
    fails = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_q", bus.q, 32'd0);
    check("rst_dbz", 32'(bus.dbz), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("basic",   32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, N+1);
    run("third",   32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, N+1);
    run("negthrd", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, N+1);
    run("negquar", 32'h0001_0000, 32'hFFFC_0000, 32'hFFFF_C000, 1'b0, 1'b0, N+1);
    run("dbzpos",  32'h0005_0000, 32'h0000_0000, Q_MAX,        1'b1, 1'b0, 1);
    run("dbzneg",  32'hFFFB_0000, 32'h0000_0000, Q_MIN,        1'b1, 1'b0, 1);
    run("ovfpos",  32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, N+1);
    run("ovfneg",  32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, N+1);

    // Backpressure: result and flags frozen while the consumer stalls
    issue(32'h0003_0000, 32'h0002_0000, lat);
    q0 = bus.q;
    check("bp_q0", q0, 32'h0001_8000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_q_%0d", i), bus.q, 32'h0001_8000);
      check($sformatf("bp_ctl_%0d", i), {28'd0, bus.out_valid, bus.in_ready, bus.dbz, bus.ovf},
            32'b1000);
    end
    retire("bp");

    // Back-to-back: accepts spaced N+2 cycles with consumer always ready
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a         = 32'h0003_0000;
    bus.b         = 32'h0002_0000;
    bus.in_valid  = 1'b1;
    nacc = 0;
    cyc  = 0;
    acc[0] = 0;
    acc[1] = 0;
    while (nacc < 2 && cyc < 300) begin
      if (bus.in_ready) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (nacc < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_spacing", 32'(acc[1] - acc[0]), 32'(N+2));
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during CALC returns to IDLE without waiting for a clock edge
    @(negedge clk);
    bus.a        = 32'h0007_0000;
    bus.b        = 32'h0003_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_q", bus.q, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("postrst", 32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 1'b0, 1'b0, N+1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
